lcd_spi_write: RTL and testbench



---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_spi_tick.sv | 35 +++
 rtl/lcd_spi_write.sv | 147 ++++++++++++++
 tb/tb_lcd_spi_write.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI write path: FSM encodings, word layout
// and the address-window/RAM-write command words the sequencers emit.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_DONE  = 4'b0100,
        ST_GAP   = 4'b1000
    } lcd_state_e;

    localparam int LCD_DC_BIT = 8;
    localparam int LCD_BYTE_W = 8;
    localparam int LCD_WORD_W = LCD_BYTE_W + 1;

    localparam logic [LCD_WORD_W-1:0] LCD_CMD_CASET = 9'h02A;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_RASET = 9'h02B;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_RAMWR = 9'h02C;

endpackage

// File: rtl/lcd_spi_tick.sv
// SCLK half-period tick: pulses every CLK_DIV enabled cycles, restarts from
// zero whenever the enable drops.
module lcd_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = '0;
        if (en && (div_cnt_q != DIV_LAST)) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    assign tick = en && (div_cnt_q == DIV_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// Serialises one 9-bit {dc, byte} LCD word per request onto the 4-wire SPI
// bus (mode 0, MSB first) and returns a one-cycle wr_done per byte.
//
// state | meaning
// IDLE  | waiting for en_write; lcd_dc keeps the last word's flag
// SHIFT | cs_n low, SCLK toggling every CLK_DIV cycles, 8 bits out
// DONE  | one cycle; wr_done is registered out of this state
// GAP   | GAP_CYCLES of cs_n high before the next request is sampled
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [LCD_WORD_W-1:0] data,
    input  logic                  en_write,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  lcd_sclk,
    output logic                  lcd_mosi,
    output logic                  lcd_cs_n,
    output logic                  lcd_dc
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    lcd_state_e            state_q, state_d;
    logic [LCD_BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  wr_done_q, wr_done_d;
    logic                  busy_q, busy_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  dc_q, dc_d;
    logic                  tick;

    lcd_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (state_q == ST_SHIFT),
        .tick      (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        wr_done_d = 1'b0;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        dc_d      = dc_q;

        case (state_q)
            ST_IDLE: begin
                if (en_write) begin
                    state_d   = ST_SHIFT;
                    shift_d   = data[LCD_BYTE_W-1:0];
                    dc_d      = data[LCD_DC_BIT];
                    mosi_d    = data[LCD_BYTE_W-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    sclk_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // falling edge: present the next bit; after bit 0 zeros shift in
                    if (sclk_q) begin
                        shift_d   = shift_q << 1;
                        mosi_d    = shift_d[LCD_BYTE_W-1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_DONE;
                            cs_n_d  = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                wr_done_d = 1'b1;
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            dc_q      <= dc_d;
        end
    end

    assign wr_done  = wr_done_q;
    assign busy     = busy_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_dc   = dc_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: a bus monitor decodes SPI words and
// wr_done timing, compared against hand-computed expectations.
module tb_lcd_spi_write;
    import lcd_pkg::*;

    typedef struct {
        logic [8:0] data;
        logic       exp_dc;
        logic [7:0] exp_byte;
    } vec_t;

    typedef struct {
        logic       dc;
        logic [7:0] b;
        int         nbits;
        int         cs_low;
        int         span;
        int         gap;
        logic       glitch;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;

    logic [8:0] data2 = '0, data1 = '0;
    logic       en2 = 1'b0, en1 = 1'b0;
    logic wd2, busy2, sclk2, mosi2, csn2, dc2;
    logic wd1, busy1, sclk1, mosi1, csn1, dc1;

    lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(3)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .data(data2), .en_write(en2),
        .wr_done(wd2), .busy(busy2), .lcd_sclk(sclk2), .lcd_mosi(mosi2),
        .lcd_cs_n(csn2), .lcd_dc(dc2)
    );

    lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(3)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .data(data1), .en_write(en1),
        .wr_done(wd1), .busy(busy1), .lcd_sclk(sclk1), .lcd_mosi(mosi1),
        .lcd_cs_n(csn1), .lcd_dc(dc1)
    );

    wire m_wd   = sel ? wd1   : wd2;
    wire m_busy = sel ? busy1 : busy2;
    wire m_sclk = sel ? sclk1 : sclk2;
    wire m_mosi = sel ? mosi1 : mosi2;
    wire m_csn  = sel ? csn1  : csn2;
    wire m_dc   = sel ? dc1   : dc2;

    always #5 clk = ~clk;

    int n_applied = 0;
    int n_miscmp  = 0;

    word_t words[$];
    int    wd_lat[$];
    int    n_wd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus monitor, sampling on the falling system clock edge.
    initial begin : monitor
        int cyc, fall_cyc, last_wd, first_rise, last_rise, nbits, gap;
        logic prev_sclk, prev_cs, dc0, glitch;
        logic [7:0] sh;
        cyc = 0; fall_cyc = 0; last_wd = 0; first_rise = -1; last_rise = 0;
        nbits = 0; gap = 0; prev_sclk = 1'b0; prev_cs = 1'b1; dc0 = 1'b0;
        glitch = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_sclk = 1'b0;
                prev_cs   = 1'b1;
                nbits     = 0;
            end else begin
                if (prev_cs && !m_csn) begin
                    fall_cyc = cyc; nbits = 0; sh = '0; glitch = 1'b0;
                    dc0 = m_dc; gap = cyc - last_wd; first_rise = -1;
                end
                if (!m_csn) begin
                    if (m_dc !== dc0) glitch = 1'b1;
                    if (!prev_sclk && m_sclk) begin
                        sh = {sh[6:0], m_mosi};
                        nbits++;
                        if (first_rise < 0) first_rise = cyc;
                        last_rise = cyc;
                    end
                end
                if (!prev_cs && m_csn) begin
                    words.push_back('{dc0, sh, nbits, cyc - fall_cyc,
                                      last_rise - first_rise, gap, glitch});
                end
                if (m_wd) begin
                    wd_lat.push_back(cyc - fall_cyc);
                    last_wd = cyc;
                    n_wd++;
                end
                prev_sclk = m_sclk;
                prev_cs   = m_csn;
            end
        end
    end

    task automatic run_vec(input vec_t v, input int div);
        words.delete();
        wd_lat.delete();
        @(posedge clk); #1;
        if (sel) begin data1 = v.data; en1 = 1'b1; end
        else     begin data2 = v.data; en2 = 1'b1; end
        @(posedge clk); #1;
        en1 = 1'b0; en2 = 1'b0;
        chk("busy_after_sample", m_busy, 1);
        repeat (16*div + 10) @(posedge clk);
        #1;
        chk("word_count", words.size(), 1);
        if (words.size() >= 1) begin
            chk("word_dc_byte", {words[0].dc, words[0].b}, {v.exp_dc, v.exp_byte});
            chk("bit_count", words[0].nbits, 8);
            chk("cs_low_cycles", words[0].cs_low, 16*div);
            chk("sclk_rise_span", words[0].span, 14*div);
            chk("dc_glitch", words[0].glitch, 0);
        end
        chk("wr_done_count", wd_lat.size(), 1);
        if (wd_lat.size() >= 1) chk("wr_done_latency", wd_lat[0], 16*div + 1);
        chk("idle_cs_n", m_csn, 1);
        chk("idle_busy", m_busy, 0);
    endtask

    initial begin : test
        vec_t       tbl[6];
        logic [8:0] w[11];
        int         cnt, nwd0;

        tbl[0] = '{LCD_CMD_CASET, 1'b0, 8'h2A};
        tbl[1] = '{9'h1A5,        1'b1, 8'hA5};
        tbl[2] = '{9'h100,        1'b1, 8'h00};
        tbl[3] = '{9'h0FF,        1'b0, 8'hFF};
        tbl[4] = '{9'h13F,        1'b1, 8'h3F};
        tbl[5] = '{LCD_CMD_RAMWR, 1'b0, 8'h2C};

        w = '{LCD_CMD_CASET, 9'h100, 9'h100, 9'h100, 9'h1EF,
              LCD_CMD_RASET, 9'h100, 9'h100, 9'h101, 9'h13F, LCD_CMD_RAMWR};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {wd2, busy2, sclk2, mosi2, csn2, dc2}, 6'b000010);
        chk("reset_outputs_div1", {wd1, busy1, sclk1, mosi1, csn1, dc1}, 6'b000010);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single one-cycle requests, CLK_DIV=2
        for (int i = 0; i < 6; i++) run_vec(tbl[i], 2);

        // en_write held, data changed mid-byte
        words.delete(); wd_lat.delete();
        @(posedge clk); #1;
        data2 = 9'h1A5; en2 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        data2 = 9'h0FF;
        for (int c = 0; c < 200 && words.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        en2 = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("held_word_count", words.size(), 2);
        if (words.size() >= 2) begin
            chk("held_word0", {words[0].dc, words[0].b}, 9'h1A5);
            chk("held_word0_glitch", words[0].glitch, 0);
            chk("held_word1", {words[1].dc, words[1].b}, 9'h0FF);
            chk("held_cs_fall_after_wr_done", words[1].gap, 4);
        end
        chk("held_wr_done_count", wd_lat.size(), 2);

        // producer emulation: new data 2 cycles after each wr_done
        words.delete(); wd_lat.delete();
        cnt = 0;
        @(posedge clk); #1;
        data2 = w[0]; en2 = 1'b1;
        for (int c = 0; c < 11*40 && cnt < 11; c++) begin
            @(posedge clk); #1;
            if (wd2) begin
                cnt++;
                if (cnt == 11) en2 = 1'b0;
                else begin
                    repeat (2) @(posedge clk);
                    #1 data2 = w[cnt];
                end
            end
        end
        en2 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("producer_wr_done", cnt, 11);
        chk("producer_word_count", words.size(), 11);
        for (int i = 0; i < 11 && i < words.size(); i++)
            chk($sformatf("producer_word%0d", i), {words[i].dc, words[i].b}, w[i]);

        // reset at the 3rd SCLK rise
        words.delete(); wd_lat.delete();
        @(posedge clk); #1;
        data2 = 9'h0F0; en2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("sclk_high_at_rise3", sclk2, 1);
        nwd0 = n_wd;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {wd2, busy2, sclk2, mosi2, csn2, dc2}, 6'b000010);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_wr_done", n_wd, nwd0);
        chk("abort_no_word", words.size(), 0);
        run_vec('{9'h1C3, 1'b1, 8'hC3}, 2);

        // en_write dropped after the 2nd bit
        words.delete(); wd_lat.delete();
        @(posedge clk); #1;
        data2 = 9'h03C; en2 = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1 en2 = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("drop_word_count", words.size(), 1);
        if (words.size() >= 1) chk("drop_word", {words[0].dc, words[0].b}, 9'h03C);
        chk("drop_wr_done_count", wd_lat.size(), 1);
        chk("drop_idle_cs_n", csn2, 1);
        chk("drop_idle_busy", busy2, 0);

        // CLK_DIV=1
        sel = 1'b1;
        run_vec('{9'h155, 1'b1, 8'h55}, 1);
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
